// File: rtl/line_buf_scheduler.sv
// Slot scheduler for the PAL-to-HD upsample line buffer: write/read slot pointers,
// occupancy, field-length detection and priming. Optional stats counters: LBS_STATS_EN.
module line_buf_scheduler #(
  parameter int SLOTS       = 8,
  parameter int SLOT_ADDR_W = 11,
  parameter int ADDR_W      = 14,
  parameter int PRIME_SHORT = 2,
  parameter int PRIME_LONG  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_line,
  input  logic                       i_rd_line,
  input  logic                       i_frame,
  input  logic                       i_stats_clr,
  output logic [ADDR_W-1:0]          o_wr_base,
  output logic [ADDR_W-1:0]          o_rd_base,
  output logic [$clog2(SLOTS):0]     o_occupancy,
  output logic                       o_rd_blank,
  output logic                       o_rd_repeat,
  output logic                       o_overflow,
  output logic                       o_long_field,
  output logic [15:0]                o_underflow_cnt,
  output logic [15:0]                o_overflow_cnt
);

  localparam int SW = $clog2(SLOTS);
  localparam int OW = SW + 1;
  localparam logic [OW-1:0] OCC_MAX   = OW'(SLOTS - 1);
  localparam logic [OW-1:0] P_SHORT   = OW'(PRIME_SHORT);
  localparam logic [OW-1:0] P_LONG    = OW'(PRIME_LONG);
  localparam logic [10:0]   LINES_MAX = 11'h7FF;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   wr_slot_reg, wr_slot_next;
  logic [SW-1:0]   rd_slot_reg, rd_slot_next;
  logic [OW-1:0]   occ_reg, occ_next;
  logic [10:0]     lines_cur_reg, lines_cur_next;
  logic [10:0]     lines_prev_reg, lines_prev_next;
  logic            long_reg, long_next;
  logic            rep_reg, rep_next;
  logic            ovf_reg, ovf_next;
  logic            wr_ok, rd_ok;
  logic [OW-1:0]   prime_depth;

  assign prime_depth = long_reg ? P_LONG : P_SHORT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_slot_reg    <= '0;
      rd_slot_reg    <= '0;
      occ_reg        <= '0;
      lines_cur_reg  <= '0;
      lines_prev_reg <= '0;
      long_reg       <= 1'b0;
      rep_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_slot_reg    <= wr_slot_next;
      rd_slot_reg    <= rd_slot_next;
      occ_reg        <= occ_next;
      lines_cur_reg  <= lines_cur_next;
      lines_prev_reg <= lines_prev_next;
      long_reg       <= long_next;
      rep_reg        <= rep_next;
      ovf_reg        <= ovf_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wr_slot_next    = wr_slot_reg;
    rd_slot_next    = rd_slot_reg;
    occ_next        = occ_reg;
    lines_cur_next  = lines_cur_reg;
    lines_prev_next = lines_prev_reg;
    long_next       = long_reg;
    rep_next        = 1'b0;
    ovf_next        = 1'b0;
    // Full/empty decisions both use the pre-edge occupancy.
    wr_ok = i_wr_line && (occ_reg < OCC_MAX);
    rd_ok = i_rd_line && (state_reg == RUN) && (occ_reg != '0);
    if (i_frame) begin
      wr_slot_next    = '0;
      rd_slot_next    = '0;
      occ_next        = '0;
      state_next      = FILL;
      lines_prev_next = lines_cur_reg;
      lines_cur_next  = '0;
      long_next       = (lines_cur_reg > lines_prev_reg);
    end else if (state_reg != IDLE) begin
      if (state_reg == FILL && occ_reg >= prime_depth)
        state_next = RUN;
      if (i_wr_line) begin
        if (lines_cur_reg != LINES_MAX)
          lines_cur_next = lines_cur_reg + 11'd1;
        if (wr_ok)
          wr_slot_next = wr_slot_reg + 1'b1;
        else
          ovf_next = 1'b1;
      end
      if (i_rd_line && state_reg == RUN) begin
        if (rd_ok)
          rd_slot_next = rd_slot_reg + 1'b1;
        else
          rep_next = 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   occ_next = occ_reg + 1'b1;
        2'b01:   occ_next = occ_reg - 1'b1;
        default: occ_next = occ_reg;
      endcase
    end
  end

  assign o_wr_base    = ADDR_W'(wr_slot_reg) << SLOT_ADDR_W;
  assign o_rd_base    = ADDR_W'(rd_slot_reg) << SLOT_ADDR_W;
  assign o_occupancy  = occ_reg;
  assign o_rd_blank   = (state_reg != RUN);
  assign o_rd_repeat  = rep_reg;
  assign o_overflow   = ovf_reg;
  assign o_long_field = long_reg;

`ifdef LBS_STATS_EN
  logic [15:0] ucnt_reg, ocnt_reg;

  // Counters track the pulses being registered this edge, so they move with them.
  always_ff @(posedge clk) begin
    if (rst || i_stats_clr) begin
      ucnt_reg <= '0;
      ocnt_reg <= '0;
    end else begin
      if (rep_next && ucnt_reg != 16'hFFFF)
        ucnt_reg <= ucnt_reg + 16'd1;
      if (ovf_next && ocnt_reg != 16'hFFFF)
        ocnt_reg <= ocnt_reg + 16'd1;
    end
  end

  assign o_underflow_cnt = ucnt_reg;
  assign o_overflow_cnt  = ocnt_reg;
`else
  logic stats_clr_unused;
  assign stats_clr_unused = i_stats_clr;
  assign o_underflow_cnt  = 16'd0;
  assign o_overflow_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_line_buf_scheduler.sv
// Bench for line_buf_scheduler: directed scenarios then random pulses, all checked
// every cycle against a queue-based model of the slot buffer.
module tb_line_buf_scheduler;

  localparam int SLOTS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wr_line = 1'b0, i_rd_line = 1'b0, i_frame = 1'b0, i_stats_clr = 1'b0;
  logic [13:0] o_wr_base, o_rd_base;
  logic [3:0]  o_occupancy;
  logic        o_rd_blank, o_rd_repeat, o_overflow, o_long_field;
  logic [15:0] o_underflow_cnt, o_overflow_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 priming, 2 running; q holds the slots written but not read.
  int m_mode = 0, m_wr = 0, m_rd = 0, m_cur = 0, m_prev = 0;
  int m_ucnt = 0, m_ocnt = 0;
  bit m_long = 0, m_rep = 0, m_ovf = 0;
  int q[$];

  line_buf_scheduler dut (
    .clk(clk), .rst(rst), .i_wr_line(i_wr_line), .i_rd_line(i_rd_line),
    .i_frame(i_frame), .i_stats_clr(i_stats_clr),
    .o_wr_base(o_wr_base), .o_rd_base(o_rd_base), .o_occupancy(o_occupancy),
    .o_rd_blank(o_rd_blank), .o_rd_repeat(o_rd_repeat), .o_overflow(o_overflow),
    .o_long_field(o_long_field), .o_underflow_cnt(o_underflow_cnt),
    .o_overflow_cnt(o_overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit wr, input bit rd, input bit fr, input bit clr, input bit rs);
    int pre;
    int new_mode;
    int prime;
    pre   = q.size();
    prime = m_long ? 3 : 2;
    m_rep = 0;
    m_ovf = 0;
    if (rs) begin
      m_mode = 0; m_wr = 0; m_rd = 0; q.delete();
      m_cur = 0; m_prev = 0; m_long = 0; m_ucnt = 0; m_ocnt = 0;
      return;
    end
    if (fr) begin
      m_long = (m_cur > m_prev);
      m_prev = m_cur;
      m_cur  = 0;
      m_wr = 0; m_rd = 0; q.delete();
      m_mode = 1;
    end else if (m_mode != 0) begin
      new_mode = (m_mode == 1 && pre >= prime) ? 2 : m_mode;
      if (wr) begin
        m_cur = (m_cur < 2047) ? m_cur + 1 : 2047;
        if (pre < SLOTS - 1) begin
          q.push_back(m_wr);
          m_wr = (m_wr + 1) % SLOTS;
        end else m_ovf = 1;
      end
      if (rd && m_mode == 2) begin
        if (pre >= 1) begin
          void'(q.pop_front());
          m_rd = (m_rd + 1) % SLOTS;
        end else m_rep = 1;
      end
      m_mode = new_mode;
    end
`ifdef LBS_STATS_EN
    if (clr) begin
      m_ucnt = 0; m_ocnt = 0;
    end else begin
      if (m_rep && m_ucnt < 65535) m_ucnt++;
      if (m_ovf && m_ocnt < 65535) m_ocnt++;
    end
`endif
  endtask

  task automatic check_all();
    chk("wr_base",   32'(o_wr_base),       32'(m_wr << 11));
    chk("rd_base",   32'(o_rd_base),       32'(m_rd << 11));
    chk("occupancy", 32'(o_occupancy),     32'(q.size()));
    chk("rd_blank",  32'(o_rd_blank),      32'(m_mode != 2));
    chk("rd_repeat", 32'(o_rd_repeat),     32'(m_rep));
    chk("overflow",  32'(o_overflow),      32'(m_ovf));
    chk("long_field",32'(o_long_field),    32'(m_long));
    chk("ucnt",      32'(o_underflow_cnt), 32'(m_ucnt));
    chk("ocnt",      32'(o_overflow_cnt),  32'(m_ocnt));
  endtask

  task automatic step(input bit wr, input bit rd, input bit fr,
                      input bit clr = 0, input bit rs = 0);
    i_wr_line = wr; i_rd_line = rd; i_frame = fr; i_stats_clr = clr; rst = rs;
    model(wr, rd, fr, clr, rs);
    @(posedge clk);
    #1;
    i_wr_line = 0; i_rd_line = 0; i_frame = 0; i_stats_clr = 0; rst = 0;
    check_all();
  endtask

  initial begin
    bit wr, rd, fr, rs, clr;
    // Reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_blank", 32'(o_rd_blank), 32'd1);
    chk("reset_occ",   32'(o_occupancy), 32'd0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("idle_ignores", 32'(o_wr_base), 32'd0);

    // Priming with depth 2
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("prime_occ",     32'(o_occupancy), 32'd2);
    chk("prime_wr_base", 32'(o_wr_base),   32'h1000);
    chk("prime_blank_1", 32'(o_rd_blank),  32'd1);
    step(0, 0, 0);
    chk("prime_blank_0", 32'(o_rd_blank),  32'd0);

    // Drain then underflow
    step(0, 1, 0);
    chk("rd1_base", 32'(o_rd_base), 32'h0800);
    step(0, 1, 0);
    chk("rd2_base", 32'(o_rd_base), 32'h1000);
    step(0, 1, 0);
    chk("rd3_repeat", 32'(o_rd_repeat), 32'd1);
    chk("rd3_base",   32'(o_rd_base),   32'h1000);
    step(0, 0, 0);
    chk("repeat_width", 32'(o_rd_repeat), 32'd0);

    // Fill to full and overflow; read+write then wraps the write slot
    step(0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    chk("full_occ",  32'(o_occupancy), 32'd7);
    chk("full_base", 32'(o_wr_base),   32'h3800);
    step(1, 0, 0);
    chk("ovf_pulse", 32'(o_overflow),  32'd1);
    chk("ovf_occ",   32'(o_occupancy), 32'd7);
    step(1, 1, 0);
    chk("both_full_occ", 32'(o_occupancy), 32'd6);
    step(1, 0, 0);
    chk("wr_wrap", 32'(o_wr_base), 32'h0000);

    // Field length detection: 312 then 313 -> long, prime depth 3
    step(0, 0, 1);
    for (int i = 0; i < 312; i++) step(1, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 313; i++) step(1, 0, 0);
    step(0, 0, 1);
    chk("long_313", 32'(o_long_field), 32'd1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("long_blank_2", 32'(o_rd_blank), 32'd1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("long_blank_3", 32'(o_rd_blank), 32'd0);
    step(0, 0, 1);
    for (int i = 0; i < 313; i++) step(1, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 312; i++) step(1, 0, 0);
    step(0, 0, 1);
    chk("short_312", 32'(o_long_field), 32'd0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("short_blank_2", 32'(o_rd_blank), 32'd0);

    // Simultaneous read/write at occupancy 3, then with a field start
    step(1, 0, 0);
    chk("sim_pre_occ", 32'(o_occupancy), 32'd3);
    step(1, 1, 0);
    chk("sim_occ",     32'(o_occupancy), 32'd3);
    chk("sim_wr_base", 32'(o_wr_base),   32'h2000);
    chk("sim_rd_base", 32'(o_rd_base),   32'h0800);
    step(1, 1, 1);
    chk("frame_wins_wr",  32'(o_wr_base),   32'd0);
    chk("frame_wins_rd",  32'(o_rd_base),   32'd0);
    chk("frame_wins_occ", 32'(o_occupancy), 32'd0);

    // Reset mid-run
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 1, 0, 0, 1);
    chk("rst_blank", 32'(o_rd_blank), 32'd1);
    chk("rst_base",  32'(o_wr_base),  32'd0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("rst_rd_ignored", 32'(o_rd_base), 32'd0);
    chk("rst_no_repeat",  32'(o_rd_repeat), 32'd0);

    // Random pulses
    for (int i = 0; i < 4000; i++) begin
      wr  = ($urandom_range(0, 99) < 45);
      rd  = ($urandom_range(0, 99) < 45);
      fr  = ($urandom_range(0, 199) == 0);
      rs  = ($urandom_range(0, 499) == 0);
      clr = ($urandom_range(0, 149) == 0);
      step(wr, rd, fr, clr, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
